// File: rtl/sram_controller.sv
// 32-bit data-memory responder for the MEM stage, split into two 16-bit
// accesses on an external asynchronous SRAM; ready stays low while busy.
module sram_controller #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N
);

   localparam int              CW       = $clog2(WAIT_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          op_wr;
   logic [16:0]   widx_q;
   logic [31:0]   wdat_q;
   logic [31:0]   offset;
   logic          req, busy, last, drv;
   logic          unused_bits;

   // Word index is taken modulo the SRAM size, so out-of-range addresses wrap.
   assign offset      = address - ADDR_BASE;
   assign unused_bits = ^{offset[31:19], offset[1:0]};

   assign req  = rd_en | wr_en;
   assign busy = (state == S_LOW) || (state == S_HIGH);
   assign last = (cnt == CNT_LAST);
   assign drv  = busy && op_wr;

   assign ready = (state == S_DONE) || ((state == S_IDLE) && !req);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         op_wr   <= 1'b0;
         widx_q  <= '0;
         wdat_q  <= '0;
         rd_data <= '0;
      end else begin
         case (state)
            S_IDLE: if (req) begin
               state  <= S_LOW;
               cnt    <= '0;
               op_wr  <= wr_en;
               widx_q <= offset[18:2];
               wdat_q <= wr_data;
            end
            S_LOW: if (last) begin
               state <= S_HIGH;
               cnt   <= '0;
               if (!op_wr) rd_data[15:0] <= SRAM_DQ;
            end else begin
               cnt <= cnt + 1'b1;
            end
            S_HIGH: if (last) begin
               state <= S_DONE;
               cnt   <= '0;
               if (!op_wr) rd_data[31:16] <= SRAM_DQ;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // WE is released on the last cycle of each phase so the address
   // never moves while a write strobe is active.
   assign SRAM_ADDR = busy ? {widx_q, (state == S_HIGH)} : 18'd0;
   assign SRAM_OE_N = !(busy && !op_wr);
   assign SRAM_WE_N = !(drv && !last);
   assign SRAM_DQ   = drv ? ((state == S_HIGH) ? wdat_q[31:16] : wdat_q[15:0]) : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed and randomized accesses
// against an SRAM device model and an abstract word-level reference.
module tb_sram_controller;

   localparam int W    = 2;
   localparam int BASE = 1024;

   logic        clk, rst, rd_en, wr_en;
   logic [31:0] address, wr_data, rd_data;
   logic        ready, we_n, oe_n;
   logic [17:0] sram_addr;
   wire  [15:0] dq;

   int checks = 0;
   int errors = 0;

   logic [15:0] dev_mem [0:262143];
   logic [15:0] ref_mem [int];
   logic [31:0] rd_exp;

   sram_controller #(.WAIT_CYCLES(W), .ADDR_BASE(32'(BASE))) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
      .SRAM_DQ(dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous SRAM device: drives on OE, stores while WE is low.
   assign dq = (!oe_n && we_n) ? dev_mem[sram_addr] : 16'hzzzz;
   always @(negedge clk) if (!we_n && oe_n) dev_mem[sram_addr] <= dq;

   function automatic logic [15:0] get_ref(int a);
      return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int a, input logic [15:0] v);
      dev_mem[a] = v;
      ref_mem[a] = v;
   endtask

   // One full access from the current cycle; caller is #1 after a rising edge.
   task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input bit drop);
      int unsigned off;
      int lo, hi, pc;
      bit in_lo, in_hi, is_wr;
      logic [31:0] e_addr;
      logic        e_we, e_oe;
      off   = a - BASE;
      lo    = int'(((off >> 2) & 32'h1FFFF) * 2);
      hi    = lo + 1;
      is_wr = wr;
      if (is_wr) begin
         ref_mem[lo] = d[15:0];
         ref_mem[hi] = d[31:16];
      end else begin
         rd_exp = {get_ref(hi), get_ref(lo)};
      end
      rd_en = rd; wr_en = wr; address = a; wr_data = d;
      for (int k = 0; k <= 2*W + 1; k++) begin
         @(negedge clk);
         in_lo  = (k >= 1) && (k <= W);
         in_hi  = (k > W) && (k <= 2*W);
         pc     = in_lo ? k - 1 : k - 1 - W;
         e_addr = in_lo ? 32'(lo) : in_hi ? 32'(hi) : 32'd0;
         e_we   = !(is_wr && (in_lo || in_hi) && pc != W - 1);
         e_oe   = !(!is_wr && (in_lo || in_hi));
         chk("ready", {31'd0, ready}, {31'd0, k == 2*W + 1});
         chk("sram_addr", {14'd0, sram_addr}, e_addr);
         chk("we_n", {31'd0, we_n}, {31'd0, e_we});
         chk("oe_n", {31'd0, oe_n}, {31'd0, e_oe});
         if (is_wr && in_lo) chk("dq_lo", {16'd0, dq}, {16'd0, d[15:0]});
         if (is_wr && in_hi) chk("dq_hi", {16'd0, dq}, {16'd0, d[31:16]});
         if (k == 2*W + 1) chk("rd_data", rd_data, rd_exp);
         @(posedge clk); #1;
         if (drop && k == 0) begin
            rd_en = 0; wr_en = 0; address = $urandom; wr_data = $urandom;
         end
      end
      rd_en = 0; wr_en = 0;
      if (is_wr) begin
         chk("mem_lo", {16'd0, dev_mem[lo]}, {16'd0, d[15:0]});
         chk("mem_hi", {16'd0, dev_mem[hi]}, {16'd0, d[31:16]});
      end
   endtask

   initial begin
      for (int i = 0; i < 262144; i++) dev_mem[i] = 16'h0000;
      rst = 0; rd_en = 0; wr_en = 0; address = 0; wr_data = 0; rd_exp = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_we_n", {31'd0, we_n}, 32'd1);
      chk("rst_oe_n", {31'd0, oe_n}, 32'd1);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      rd_en = 1; #1;
      chk("rst_ready_req", {31'd0, ready}, 32'd0);
      rd_en = 0;
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1;

      // Write then read back
      access(0, 1, 32'd1028, 32'hDEADBEEF, 0);
      chk("wr_addr2", {16'd0, dev_mem[2]}, 32'h0000BEEF);
      chk("wr_addr3", {16'd0, dev_mem[3]}, 32'h0000DEAD);
      access(1, 0, 32'd1028, 32'h0, 0);
      chk("rd_1028", rd_data, 32'hDEADBEEF);

      // Back-to-back reads from preloaded words
      preload(0, 16'h1111); preload(1, 16'h2222);
      preload(4, 16'h5555); preload(5, 16'h6666);
      access(1, 0, 32'd1024, 32'h0, 0);
      chk("b2b_first", rd_data, 32'h22221111);
      access(1, 0, 32'd1032, 32'h0, 0);
      chk("b2b_second", rd_data, 32'h66665555);

      // Both enables: treated as a write, rd_data untouched
      access(1, 1, 32'd1024, 32'h12345678, 0);
      chk("both_rd_hold", rd_data, 32'h66665555);
      access(1, 0, 32'd1024, 32'h0, 0);
      chk("both_readback", rd_data, 32'h12345678);

      // Address below the base wraps to the top of the SRAM
      access(0, 1, 32'd1020, 32'hA5A5C3C3, 0);
      chk("wrap_lo", {16'd0, dev_mem[18'h3FFFE]}, 32'h0000C3C3);
      access(1, 0, 32'd1020, 32'h0, 0);

      // Randomized traffic, some requests dropped after the first cycle
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a, d;
         bit wr, drop;
         a    = 32'(BASE) + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
         d    = $urandom;
         wr   = ($urandom_range(0, 1) == 1);
         drop = ($urandom_range(0, 3) == 0);
         access(!wr, wr, a, d, drop);
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, ready}, 32'd1);
            @(posedge clk); #1;
         end
      end

      // Reset in the middle of a write
      rd_en = 0; wr_en = 1; address = 32'(BASE + 4 * 1000); wr_data = 32'hCAFEF00D;
      repeat (2) begin @(posedge clk); #1; end
      rst = 0; #1;
      chk("mid_rst_we_n", {31'd0, we_n}, 32'd1);
      chk("mid_rst_oe_n", {31'd0, oe_n}, 32'd1);
      chk("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
      chk("mid_rst_rd_data", rd_data, 32'd0);
      chk("mid_rst_ready_req", {31'd0, ready}, 32'd0);
      wr_en = 0; #1;
      chk("mid_rst_ready", {31'd0, ready}, 32'd1);
      rd_exp = 0;
      @(posedge clk); #1; rst = 1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_ready", {31'd0, ready}, 32'd1);
         chk("post_rst_we_n", {31'd0, we_n}, 32'd1);
         chk("post_rst_addr", {14'd0, sram_addr}, 32'd0);
      end
      @(posedge clk); #1;
      access(1, 0, 32'd1024, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the MEM stage's data-memory request interface. It accepts a 32-bit read or write from the pipeline and executes it as two consecutive 16-bit accesses on an external asynchronous SRAM. While an access is in flight it holds `ready` low so the pipeline freezes. It replaces the single-cycle data memory behind the MEM stage; the pipeline is the initiator and this block is the responder.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: cycles per 16-bit SRAM phase. Legal values are ≥2.
- `ADDR_BASE`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `rd_en` in 1: read request from MEM stage. Held stable while `ready`=0.
- `wr_en` in 1: write request from MEM stage. Held stable while `ready`=0.
- `address` in 32: byte address. Bits [1:0] are ignored.
- `wr_data` in 32: write data.
- `rd_data` out 32: last completed read word.
- `ready` out 1: 0 means the pipeline must freeze.
- `SRAM_DQ` inout 16: SRAM data bus. Tri-state when not writing.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: SRAM write enable, active-low.
- `SRAM_OE_N` out 1: SRAM output enable, active-low.

## Operation
- Word index `widx = (address - ADDR_BASE)[19:2]`, computed modulo 2^32.
  - Low half-word lives at SRAM address `{widx[16:0],1'b0}`.
  - High half-word lives at SRAM address `{widx[16:0],1'b1}`.
  - Out-of-range addresses wrap; no error is flagged.
- Request = `rd_en | wr_en`. If both are high, the access is a write (illegal from the pipeline, but defined).
- FSM states: IDLE, LOW, HIGH, DONE. A phase counter `cnt` counts 0..WAIT_CYCLES-1.
  - IDLE: no request → stay in IDLE. Request → go to LOW with `cnt`=0. Latch op type (read/write) and `widx`.
  - LOW: `cnt` increments. At `cnt`=WAIT_CYCLES-1, go to HIGH with `cnt`=0.
  - HIGH: same as LOW, but at the end go to DONE.
  - DONE: always go to IDLE after one cycle.
- `ready` is combinational:
  - 1 in DONE.
  - 1 in IDLE with no request.
  - 0 in IDLE with a request, and 0 in LOW and HIGH.
- Read phases:
  - `SRAM_OE_N`=0, `SRAM_WE_N`=1, `SRAM_DQ`=Z.
  - On the last cycle of LOW, capture `SRAM_DQ` into `rd_data[15:0]`.
  - On the last cycle of HIGH, capture `SRAM_DQ` into `rd_data[31:16]`.
- Write phases:
  - `SRAM_OE_N`=1. `SRAM_DQ` = `wr_data[15:0]` in LOW and `wr_data[31:16]` in HIGH, driven for the whole phase.
  - `SRAM_WE_N`=0 for `cnt` 0..WAIT_CYCLES-2 and 1 on the last cycle of each phase, so the address never changes under an active WE.
- Writes never change `rd_data`. `rd_data` holds its value between reads.
- In IDLE and DONE: `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z.
- Reset values: state IDLE, `cnt`=0, `rd_data`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0. `ready` follows the request combinationally.

## Timing
- A request first seen in IDLE at cycle 0 drops `ready` the same cycle.
- LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W, where W = WAIT_CYCLES.
- DONE is at cycle 2W+1. `ready`=1 there and `rd_data` is valid, so the pipeline advances on that edge.
- `ready` is low for 2W+1 cycles. With W=2, that is 5 stall cycles and a 6-cycle access.
- Request asserted in the cycle after DONE (back-to-back): treated as a new access starting from IDLE. DONE never re-triggers.
- Request deasserted mid-access: the access still completes. Inputs are latched at the IDLE→LOW transition.
- Reset asserted mid-access: immediately return to IDLE and release the bus. The aborted write is partial; this is acceptable.

## Test plan
- Reset: hold `rst`=0 with `rd_en`=0 → `rd_data`=0, `ready`=1, WE_N=OE_N=1, DQ=Z.
- Write then read, W=2: write 0xDEADBEEF to address 1028 → SRAM addr 2 receives 0xBEEF and addr 3 receives 0xDEAD. `ready` is low cycles 0-4 and high in cycle 5.
  - Then read 1028 → `rd_data`=0xDEADBEEF at DONE.
- Back-to-back reads of 1024 and 1032 (SRAM model preloaded 0x1111/0x2222 and 0x5555/0x6666) → `rd_data`=0x22221111, then 0x66665555. No missing or duplicate access.
- WE timing during a write: `SRAM_WE_N` pattern is 0,1,0,1 across cycles 1-4, and `SRAM_ADDR` changes only when WE_N=1.
- Reset mid-write: `rst` low at cycle 2 → outputs at reset values at once. After release with no request, the block stays in IDLE with `ready`=1.
- `rd_en`=`wr_en`=1 with `wr_data`=0x12345678 at address 1024 → a write is performed and `rd_data` is unchanged.
